char_buf_port_arbiter: RTL and testbench

- Owns port 2 of the character-buffer on-chip SRAM (2048 x 32, 11-bit word address, 4 byte lanes, registered address, unregistered q, 1-cycle read latency).
- Shares that port between three requesters, in fixed priority:
  1. The VGA character scan-out reader.
  2. A host Avalon-MM-style master.
  3. An internal clear-screen engine that fills the whole buffer with a fill word.
- Port 1 of the SRAM is outside this block.

---
 rtl/char_buf_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_char_buf_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buf_port_arbiter.sv
// Port-2 arbiter for the character-buffer SRAM: scan reader > host master > clear engine.
// Define CHAR_BUF_ARB_STARVE_GUARD_EN to force an occasional host grant over a continuous scan stream.
module char_buf_port_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
`ifdef CHAR_BUF_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_req,
  input  logic [ADDR_W-1:0]   scan_addr,
  output logic                scan_ack,
  output logic                scan_valid,
  output logic [DATA_W-1:0]   scan_data,
  input  logic                host_read,
  input  logic                host_write,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W/8-1:0] host_byteenable,
  input  logic [DATA_W-1:0]   host_writedata,
  output logic                host_waitrequest,
  output logic                host_readdatavalid,
  output logic [DATA_W-1:0]   host_readdata,
  input  logic                clear_start,
  input  logic [DATA_W-1:0]   clear_word,
  output logic                clear_busy,
  output logic                clear_done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  // state | meaning
  // IDLE  | no clear in progress, clear_start accepted
  // CLEAR | filling words 0..DEPTH-1 whenever the port is otherwise free

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t        state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] fill;
  logic              host_req;
  logic              force_host;
  logic              grant_scan;
  logic              grant_host;
  logic              grant_clr;

  assign host_req = host_read | host_write;

`ifdef CHAR_BUF_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  assign force_host = host_req & (starve_cnt == STARVE_MAX);

  // Counts host stalls caused only by scan traffic; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_host) begin
      starve_cnt <= '0;
    end else if (host_req && grant_scan && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_host = 1'b0;
`endif

  // Grants are gated by reset so the SRAM sees no traffic while reset is held.
  assign grant_scan = reset & scan_req & ~force_host;
  assign grant_host = reset & host_req & ~grant_scan;
  assign grant_clr  = reset & (state == CLEAR) & ~scan_req & ~host_req;

  assign scan_ack         = grant_scan;
  assign host_waitrequest = ~reset | (host_req & ~grant_host);
  assign scan_data        = mem_readdata;
  assign host_readdata    = mem_readdata;
  assign mem_clken        = 1'b1;

  always_comb begin
    mem_chipselect = grant_scan | grant_host | grant_clr;
    mem_write      = 1'b0;
    mem_address    = host_addr;
    mem_byteenable = host_byteenable;
    mem_writedata  = host_writedata;
    if (grant_scan) begin
      mem_address    = scan_addr;
      mem_byteenable = {BE_W{1'b1}};
    end else if (grant_host) begin
      mem_write      = host_write;
    end else if (grant_clr) begin
      mem_write      = 1'b1;
      mem_address    = clr_cnt[ADDR_W-1:0];
      mem_byteenable = {BE_W{1'b1}};
      mem_writedata  = fill;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      clr_cnt            <= '0;
      fill               <= '0;
      clear_busy         <= 1'b0;
      clear_done         <= 1'b0;
      scan_valid         <= 1'b0;
      host_readdatavalid <= 1'b0;
    end else begin
      scan_valid         <= grant_scan;
      // Simultaneous read and write is handled as a write, so no read data follows.
      host_readdatavalid <= grant_host & host_read & ~host_write;
      clear_done         <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            fill       <= clear_word;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (grant_clr) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_WORD) begin
              state      <= IDLE;
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_buf_port_arbiter.sv
// Randomised and directed bench for char_buf_port_arbiter with an SRAM stub and a
// priority/queue-level reference model compared on every cycle.
module tb_char_buf_port_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 2048;
  localparam int LIMIT = 16;
`ifdef CHAR_BUF_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_ack;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          host_read;
  logic          host_write;
  logic [AW-1:0] host_addr;
  logic [BW-1:0] host_byteenable;
  logic [DW-1:0] host_writedata;
  logic          host_waitrequest;
  logic          host_readdatavalid;
  logic [DW-1:0] host_readdata;
  logic          clear_start;
  logic [DW-1:0] clear_word;
  logic          clear_busy;
  logic          clear_done;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_write;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic          mem_clken;
  logic [DW-1:0] mem_readdata;

  always #5 clk = ~clk;

  char_buf_port_arbiter dut (
    .clk(clk), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_ack(scan_ack),
    .scan_valid(scan_valid), .scan_data(scan_data),
    .host_read(host_read), .host_write(host_write), .host_addr(host_addr),
    .host_byteenable(host_byteenable), .host_writedata(host_writedata),
    .host_waitrequest(host_waitrequest), .host_readdatavalid(host_readdatavalid),
    .host_readdata(host_readdata),
    .clear_start(clear_start), .clear_word(clear_word),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // SRAM stub: registered address, unregistered q.
  logic [DW-1:0] sram [0:DEPTH-1];
  logic [AW-1:0] sram_aq;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) sram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      sram_aq <= mem_address;
    end
  end
  assign mem_readdata = sram[sram_aq];

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit            m_clr;
  int            m_pos;
  logic [DW-1:0] m_fill;
  int            m_starve;
  logic [DW-1:0] shadow [0:DEPTH-1];
  bit            known  [0:DEPTH-1];
  bit            e_sv, e_hv, e_done, e_sk, e_hk;
  logic [DW-1:0] e_sd, e_hd;

  // Samples of DUT outputs taken by the compare step.
  logic          s_scan_ack, s_hwait, s_cs, s_write, s_sv, s_hv, s_busy, s_done;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_sd, s_hd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    bit rst, hreq, frc, was_clr;
    int win;  // 0 none, 1 scan, 2 host, 3 clear
    rst  = !reset;
    hreq = host_read || host_write;
    win  = 0;
    if (!rst) begin
      frc = GUARD && (m_starve >= LIMIT) && hreq;
      if (scan_req && !frc) win = 1;
      else if (hreq)        win = 2;
      else if (m_clr)       win = 3;
    end

    chk("scan_ack", scan_ack, 32'(win == 1));
    chk("host_waitrequest", host_waitrequest, 32'(rst || (hreq && win != 2)));
    chk("mem_chipselect", mem_chipselect, 32'(win != 0));
    chk("mem_write", mem_write, 32'((win == 2 && host_write) || win == 3));
    chk("mem_clken", mem_clken, 32'd1);
    if (win == 1) begin
      chk("scan mem_address", 32'(mem_address), 32'(scan_addr));
      chk("scan mem_byteenable", 32'(mem_byteenable), 32'hF);
    end else if (win == 2) begin
      chk("host mem_address", 32'(mem_address), 32'(host_addr));
      chk("host mem_byteenable", 32'(mem_byteenable), 32'(host_byteenable));
      chk("host mem_writedata", mem_writedata, host_writedata);
    end else if (win == 3) begin
      chk("clear mem_address", 32'(mem_address), 32'(m_pos));
      chk("clear mem_byteenable", 32'(mem_byteenable), 32'hF);
      chk("clear mem_writedata", mem_writedata, m_fill);
    end
    chk("scan_valid", scan_valid, 32'(e_sv));
    if (e_sv && e_sk) chk("scan_data", scan_data, e_sd);
    chk("host_readdatavalid", host_readdatavalid, 32'(e_hv));
    if (e_hv && e_hk) chk("host_readdata", host_readdata, e_hd);
    chk("valids exclusive", 32'(scan_valid && host_readdatavalid), 32'd0);
    chk("clear_busy", clear_busy, 32'(m_clr));
    chk("clear_done", clear_done, 32'(e_done));

    s_scan_ack = scan_ack; s_hwait = host_waitrequest; s_cs = mem_chipselect;
    s_write = mem_write; s_addr = mem_address; s_sv = scan_valid; s_sd = scan_data;
    s_hv = host_readdatavalid; s_hd = host_readdata; s_busy = clear_busy; s_done = clear_done;

    if (rst) begin
      m_clr = 0; m_pos = 0; m_fill = '0; m_starve = 0;
      e_sv = 0; e_hv = 0; e_done = 0;
    end else begin
      was_clr = m_clr;
      e_sv = (win == 1); e_sk = known[scan_addr]; e_sd = shadow[scan_addr];
      e_hv = (win == 2) && host_read && !host_write;
      e_hk = known[host_addr]; e_hd = shadow[host_addr];
      e_done = 0;
      if (win == 2 && host_write) begin
        for (int b = 0; b < BW; b++)
          if (host_byteenable[b]) shadow[host_addr][8*b +: 8] = host_writedata[8*b +: 8];
        if (host_byteenable == 4'hF) known[host_addr] = 1;
      end
      if (win == 3) begin
        shadow[m_pos] = m_fill;
        known[m_pos] = 1;
        if (m_pos == DEPTH - 1) begin
          m_clr = 0;
          e_done = 1;
        end else begin
          m_pos++;
        end
      end
      if (!was_clr && clear_start) begin
        m_clr = 1; m_pos = 0; m_fill = clear_word;
      end
      if (win == 2) m_starve = 0;
      else if (hreq && win == 1 && m_starve < LIMIT) m_starve++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic host_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    host_read = 1; host_addr = a;
    tick();
    host_read = 0;
    tick();
    chk({nm, " valid"}, 32'(s_hv), 32'd1);
    chk(nm, s_hd, exp);
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_write = 1; host_addr = a; host_writedata = d; host_byteenable = 4'hF;
    tick();
    host_write = 0;
  endtask

  int busy_n, done_n, first, ack_at, ack_next, hsel;
  bit hit;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      shadow[i] = '0;
      known[i] = 0;
    end
    m_clr = 0; m_pos = 0; m_fill = '0; m_starve = 0;
    e_sv = 0; e_hv = 0; e_done = 0; e_sk = 0; e_hk = 0; e_sd = '0; e_hd = '0;
    reset = 0; scan_req = 1; scan_addr = '0; host_read = 1; host_write = 0;
    host_addr = '0; host_byteenable = 4'hF; host_writedata = '0;
    clear_start = 1; clear_word = 32'hFFFF_FFFF;

    // Reset held with every requester active.
    repeat (3) begin
      tick();
      chk("reset chipselect", 32'(s_cs), 32'd0);
      chk("reset waitrequest", 32'(s_hwait), 32'd1);
      chk("reset registered outs", 32'({s_sv, s_hv, s_busy, s_done}), 32'd0);
    end
    clear_start = 0; reset = 1;
    tick();
    chk("first grant is scan", 32'(s_scan_ack), 32'd1);
    scan_req = 0; host_read = 0;
    tick();

    // Host write then read back.
    host_write = 1; host_addr = 11'h005; host_writedata = 32'hDEADBEEF; host_byteenable = 4'hF;
    tick();
    chk("host write waitrequest", 32'(s_hwait), 32'd0);
    host_write = 0; host_read = 1;
    tick();
    chk("host read waitrequest", 32'(s_hwait), 32'd0);
    host_read = 0;
    tick();
    chk("host readdatavalid", 32'(s_hv), 32'd1);
    chk("host readdata", s_hd, 32'hDEADBEEF);

    // Scan and host collide.
    host_wr(11'h010, 32'h1111_1111);
    host_wr(11'h020, 32'h2222_2222);
    scan_req = 1; scan_addr = 11'h010; host_read = 1; host_addr = 11'h020;
    tick();
    chk("collide scan_ack", 32'(s_scan_ack), 32'd1);
    chk("collide waitrequest", 32'(s_hwait), 32'd1);
    scan_req = 0;
    tick();
    chk("host after scan waitrequest", 32'(s_hwait), 32'd0);
    chk("collide scan_data", s_sd, 32'h1111_1111);
    host_read = 0;
    tick();
    chk("collide host valid", 32'(s_hv), 32'd1);
    chk("collide host data", s_hd, 32'h2222_2222);
    chk("collide scan valid low", 32'(s_sv), 32'd0);

    // Undisturbed clear.
    clear_word = 32'h2020_2020; clear_start = 1;
    tick();
    clear_start = 0; busy_n = 0; done_n = 0;
    for (int i = 0; i < 2100; i++) begin
      tick();
      busy_n += int'(s_busy);
      done_n += int'(s_done);
    end
    chk("clear busy cycles", 32'(busy_n), 32'd2048);
    chk("clear done pulses", 32'(done_n), 32'd1);
    host_rd(11'h000, 32'h2020_2020, "fill 0x000");
    host_rd(11'h3FF, 32'h2020_2020, "fill 0x3FF");
    host_rd(11'h7FF, 32'h2020_2020, "fill 0x7FF");

    // Clear sharing the port with a scan stream on every other cycle.
    clear_word = 32'h5A5A_5A5A; clear_start = 1;
    tick();
    clear_start = 0; busy_n = 0; done_n = 0;
    for (int i = 0; i < 4200; i++) begin
      scan_req = (i % 2 == 0);
      scan_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      busy_n += int'(s_busy);
      done_n += int'(s_done);
    end
    scan_req = 0;
    chk("shared clear busy cycles", 32'(busy_n), 32'd4096);
    chk("shared clear done pulses", 32'(done_n), 32'd1);

    // Reset in the middle of a clear.
    clear_word = 32'h0000_00AA; clear_start = 1;
    tick();
    clear_start = 0; hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      tick();
      if (s_cs && s_write && s_addr == 11'h100) hit = 1;
    end
    chk("clear reached 0x100", 32'(hit), 32'd1);
    reset = 0;
    tick();
    reset = 1; busy_n = 0; done_n = 0;
    repeat (20) begin
      tick();
      busy_n += int'(s_busy);
      done_n += int'(s_done);
    end
    chk("aborted clear busy", 32'(busy_n), 32'd0);
    chk("aborted clear done", 32'(done_n), 32'd0);

    // Continuous scan stream with a pending host read.
    scan_req = 1; scan_addr = 11'h001; host_read = 1; host_addr = 11'h005;
    first = 0; ack_at = -1; ack_next = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (!s_hwait && first == 0) begin
        first = c;
        ack_at = int'(s_scan_ack);
      end else if (first != 0 && c == first + 1) begin
        ack_next = int'(s_scan_ack);
      end
    end
    scan_req = 0; host_read = 0;
    if (GUARD) begin
      chk("starve grant cycle", 32'(first), 32'd17);
      chk("starve scan_ack low", 32'(ack_at), 32'd0);
      chk("starve scan_ack back", 32'(ack_next), 32'd1);
    end else begin
      chk("host starved", 32'(first), 32'd0);
    end
    tick();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 799) != 0);
      scan_req = 1'($urandom_range(0, 1));
      scan_addr = AW'($urandom_range(0, 63));
      hsel = $urandom_range(0, 3);
      host_read = (hsel == 0);
      host_write = (hsel == 1);
      host_addr = AW'($urandom_range(0, 63));
      host_byteenable = BW'($urandom_range(0, 15));
      host_writedata = $urandom;
      clear_start = ($urandom_range(0, 299) == 0);
      clear_word = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
